// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the byte-serial RAM arbiter: request codes, funct3 codes,
// FSM encoding and the transfer-length helper.
package mem_arbiter_pkg;

    localparam int ADDR_W_DEF = 32;

    localparam logic [1:0] MEM_NONE  = 2'b00;
    localparam logic [1:0] MEM_LOAD  = 2'b01;
    localparam logic [1:0] MEM_STORE = 2'b10;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_e;

    // Index of the last byte of a transfer (N-1), selected by the size bits of funct3.
    function automatic logic [1:0] last_byte_idx(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 2'd0;
            2'b01:   return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter_load_ext.sv
// Combinational load extension of an assembled little-endian word by funct3.
// Kept standalone so the MEM stage can reuse it.
module mem_arbiter_load_ext
    import mem_arbiter_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] ext_o
);

    always_comb begin
        ext_o = word_i;
        case (funct3_i)
            F3_LB:   ext_o = {{24{word_i[7]}}, word_i[7:0]};
            F3_LH:   ext_o = {{16{word_i[15]}}, word_i[15:0]};
            F3_LBU:  ext_o = {24'd0, word_i[7:0]};
            F3_LHU:  ext_o = {16'd0, word_i[15:0]};
            default: ext_o = word_i;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Owner of the byte-wide RAM port: arbitrates IF and MEM requests, serialises them
// into byte cycles, assembles read bytes and returns one-cycle done pulses.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter bit RR_EN  = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy_in,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_done,
    output logic [31:0]       if_data,
    input  logic [1:0]        mem_req,
    input  logic [2:0]        mem_funct3,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic              mem_done,
    output logic [31:0]       mem_rdata,
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_wr,
    output logic [7:0]        ram_dout,
    input  logic [7:0]        ram_din,
    output arb_state_e        dbg_state
);

    arb_state_e        state_q, state_d;
    owner_e            owner_q, last_grant_q;
    logic              store_q;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [1:0]        last_q;
    logic [1:0]        cnt_q;
    logic              rd_pend_q;
    logic [1:0]        rd_idx_q;
    logic [31:0]       word_q;

    logic        mem_valid;
    logic        grant_if;
    logic        grant_mem;
    logic        flush_hit;
    logic        xfer_last;
    logic [31:0] ext_word;

    assign mem_valid = (mem_req == MEM_LOAD) || (mem_req == MEM_STORE);
    assign flush_hit = if_flush && (state_q != ST_IDLE) && (owner_q == OWN_IF);
    assign xfer_last = (cnt_q == last_q);
    assign dbg_state = state_q;

    // Grants are only sampled in IDLE; a stalled RAM defers the decision.
    always_comb begin
        grant_if  = 1'b0;
        grant_mem = 1'b0;
        if (state_q == ST_IDLE && rdy_in) begin
            if (mem_valid && if_req) begin
                if (RR_EN && last_grant_q == OWN_MEM) grant_if = 1'b1;
                else grant_mem = 1'b1;
            end else if (mem_valid) begin
                grant_mem = 1'b1;
            end else if (if_req) begin
                grant_if = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush_hit) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (grant_if || grant_mem) state_d = ST_XFER;
                ST_XFER: if (rdy_in && xfer_last) state_d = store_q ? ST_DONE : ST_WAIT;
                ST_WAIT: if (rdy_in) state_d = ST_DONE;
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Read byte k is issued in one cycle and captured from ram_din in the next.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q      <= OWN_IF;
            last_grant_q <= OWN_IF;
            store_q      <= 1'b0;
            f3_q         <= 3'd0;
            addr_q       <= '0;
            wdata_q      <= 32'd0;
            last_q       <= 2'd0;
            cnt_q        <= 2'd0;
            rd_pend_q    <= 1'b0;
            rd_idx_q     <= 2'd0;
            word_q       <= 32'd0;
        end else begin
            if (rdy_in) begin
                if (rd_pend_q) word_q[{rd_idx_q, 3'b000} +: 8] <= ram_din;
                rd_pend_q <= (state_q == ST_XFER) && !store_q && !flush_hit;
                rd_idx_q  <= cnt_q;
                if (state_q == ST_XFER && !xfer_last) cnt_q <= cnt_q + 2'd1;
            end
            if (flush_hit) rd_pend_q <= 1'b0;
            if (grant_if || grant_mem) begin
                owner_q      <= grant_if ? OWN_IF : OWN_MEM;
                last_grant_q <= grant_if ? OWN_IF : OWN_MEM;
                store_q      <= grant_mem && (mem_req == MEM_STORE);
                f3_q         <= grant_mem ? mem_funct3 : F3_LW;
                addr_q       <= grant_if ? if_addr : mem_addr;
                wdata_q      <= mem_wdata;
                last_q       <= grant_if ? 2'd3 : last_byte_idx(mem_funct3);
                cnt_q        <= 2'd0;
                word_q       <= 32'd0;
            end
        end
    end

    mem_arbiter_load_ext u_load_ext (
        .word_i   (word_q),
        .funct3_i (f3_q),
        .ext_o    (ext_word)
    );

    always_comb begin
        if_done   = 1'b0;
        if_data   = 32'd0;
        mem_done  = 1'b0;
        mem_rdata = 32'd0;
        ram_a     = '0;
        ram_wr    = 1'b0;
        ram_dout  = 8'd0;
        case (state_q)
            ST_XFER: begin
                ram_a = addr_q + ADDR_W'(cnt_q);
                if (store_q) begin
                    ram_wr   = rdy_in;
                    ram_dout = wdata_q[{cnt_q, 3'b000} +: 8];
                end
            end
            ST_WAIT: ram_a = addr_q + ADDR_W'(cnt_q);
            ST_DONE: begin
                if (owner_q == OWN_IF) begin
                    if_done = !if_flush;
                    if_data = if_flush ? 32'd0 : word_q;
                end else begin
                    mem_done  = 1'b1;
                    mem_rdata = store_q ? 32'd0 : ext_word;
                end
            end
            default: ;
        endcase
    end

endmodule
